// File: rtl/aes128_decrypt_ctrl.sv
// Iterative AES-128 decryption controller: steps an external decrypt_round datapath
// through rounds 9..1 and performs the unpaired initial ARK/ISR/ISB and final ARK itself.
`timescale 1ns/1ps

module aes128_inv_sbox (
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // a^254 = product of a^2, a^4, ..., a^128; maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    logic [7:0] unaffine;

    assign unaffine = {byte_i[6:0], byte_i[7]}
                    ^ {byte_i[4:0], byte_i[7:5]}
                    ^ {byte_i[1:0], byte_i[7:2]}
                    ^ 8'h05;
    assign byte_o   = gf_inv(unaffine);
endmodule

module aes128_inv_shift_rows (
    input  logic [127:0] state_i,
    output logic [127:0] state_o
);
    genvar gi;
    // Byte gi sits at row gi%4, column gi/4; row r rotates right by r columns.
    for (gi = 0; gi < 16; gi++) begin : g_byte
        localparam int ROW = gi % 4;
        localparam int COL = gi / 4;
        localparam int SRC = ((COL - ROW + 4) % 4) * 4 + ROW;
        assign state_o[127-8*gi -: 8] = state_i[127-8*SRC -: 8];
    end
endmodule

module aes128_inv_sub_bytes (
    input  logic [127:0] state_i,
    output logic [127:0] state_o
);
    genvar gi;
    for (gi = 0; gi < 16; gi++) begin : g_sbox
        aes128_inv_sbox u_sbox (
            .byte_i (state_i[127-8*gi -: 8]),
            .byte_o (state_o[127-8*gi -: 8])
        );
    end
endmodule

module aes128_decrypt_ctrl #(
    parameter int NR     = 10,
    parameter int KEY_AW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      out_data,
    output logic [KEY_AW-1:0] key_addr,
    input  logic [127:0]      key_data,
    output logic [127:0]      dp_key,
    output logic [127:0]      dp_state,
    input  logic [127:0]      dp_result,
    output logic              busy,
    output logic [3:0]        round_idx
);
    // An unsupported round count or too narrow a key address leaves the block idle forever.
    localparam bit                CFG_OK     = (NR == 10) && (KEY_AW >= 4);
    localparam logic [KEY_AW-1:0] KEY_FIRST  = KEY_AW'(NR);
    localparam logic [KEY_AW-1:0] KEY_SECOND = KEY_AW'(NR - 1);
    localparam logic [3:0]        RND_FIRST  = 4'(NR - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [127:0]      blk_q, blk_d;
    logic [3:0]        rnd_q, rnd_d;
    logic [KEY_AW-1:0] key_addr_q, key_addr_d;
    logic [127:0]      out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;

    logic [127:0]      ark_out;
    logic [127:0]      isr_out;
    logic [127:0]      init_out;
    logic [3:0]        rnd_dec;

    // The same ARK result feeds the init path (with K10) and the output (with K0).
    assign ark_out = blk_q ^ key_data;
    assign rnd_dec = rnd_q - 4'd1;

    aes128_inv_shift_rows u_isr (
        .state_i (ark_out),
        .state_o (isr_out)
    );

    aes128_inv_sub_bytes u_isb (
        .state_i (isr_out),
        .state_o (init_out)
    );

    always_comb begin
        state_d     = state_q;
        blk_d       = blk_q;
        rnd_d       = rnd_q;
        key_addr_d  = key_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && CFG_OK) begin
                    blk_d      = in_data;
                    key_addr_d = KEY_FIRST;
                    state_d    = S_INIT;
                end
            end
            S_INIT: begin
                blk_d      = init_out;
                rnd_d      = RND_FIRST;
                key_addr_d = KEY_SECOND;
                state_d    = S_ROUND;
            end
            S_ROUND: begin
                blk_d      = dp_result;
                rnd_d      = rnd_dec;
                key_addr_d = KEY_AW'(rnd_dec);
                if (rnd_q == 4'd1) state_d = S_FINAL;
            end
            S_FINAL: begin
                out_data_d  = ark_out;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            blk_q       <= '0;
            rnd_q       <= '0;
            key_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            blk_q       <= blk_d;
            rnd_q       <= rnd_d;
            key_addr_q  <= key_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_INIT) || (state_q == S_ROUND) || (state_q == S_FINAL);
    assign round_idx = rnd_q;
    assign key_addr  = key_addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign dp_key    = key_data;
    assign dp_state  = blk_q;
endmodule

// File: tb/tb_aes128_decrypt_ctrl.sv
// Bench for aes128_decrypt_ctrl: supplies the round-key store and decrypt_round datapath,
// and checks each block against a FIPS-197 InvCipher model and known vectors.
`timescale 1ns/1ps

module tb_aes128_decrypt_ctrl;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   key_addr;
    logic [127:0] key_data;
    logic [127:0] dp_key;
    logic [127:0] dp_state;
    logic [127:0] dp_result;
    logic         busy;
    logic [3:0]   round_idx;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox     [256];
    logic [7:0]   inv_sbox [256];
    logic [127:0] rk_tab    [11];
    logic [127:0] key_store [16];

    aes128_decrypt_ctrl #(.NR(10), .KEY_AW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .key_addr  (key_addr),
        .key_data  (key_data),
        .dp_key    (dp_key),
        .dp_state  (dp_state),
        .dp_result (dp_result),
        .busy      (busy),
        .round_idx (round_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // key_addr is a register, so indexing the array with it behaves as a registered-address store.
    assign key_data = key_store[key_addr];
    always_comb dp_result = dec_round(dp_state, dp_key);

    function automatic logic [7:0] gb(input logic [127:0] x, input int i);
        return x[127-8*i -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [127:0] isr(input logic [127:0] x);
        logic [127:0] y;
        y = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                y[127-8*(((c + r) % 4) * 4 + r) -: 8] = gb(x, c * 4 + r);
        return y;
    endfunction

    function automatic logic [127:0] isb(input logic [127:0] x);
        logic [127:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) y[127-8*i -: 8] = inv_sbox[gb(x, i)];
        return y;
    endfunction

    function automatic logic [127:0] imc(input logic [127:0] x);
        logic [127:0] y;
        logic [7:0]   a0, a1, a2, a3;
        y = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = gb(x, 4*c);
            a1 = gb(x, 4*c + 1);
            a2 = gb(x, 4*c + 2);
            a3 = gb(x, 4*c + 3);
            y[127-8*(4*c)   -: 8] = gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9);
            y[127-8*(4*c+1) -: 8] = gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13);
            y[127-8*(4*c+2) -: 8] = gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11);
            y[127-8*(4*c+3) -: 8] = gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14);
        end
        return y;
    endfunction

    // External shared round datapath: ARK -> IMC -> ISR -> ISB.
    function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] k);
        return isb(isr(imc(s ^ k)));
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // Textbook InvCipher ordering, independent of how the controller groups the steps.
    function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
        logic [127:0] s;
        s = ct ^ rk_tab[10];
        for (int r = 9; r >= 1; r--) begin
            s = isr(s);
            s = isb(s);
            s = s ^ rk_tab[r];
            s = imc(s);
        end
        s = isb(isr(s));
        return s ^ rk_tab[0];
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic build_tables();
        logic [7:0] ex [255];
        int         lg [256];
        logic [7:0] b;
        ex[0] = 8'h01;
        lg[1] = 0;
        for (int i = 1; i < 255; i++) begin
            ex[i] = ex[i-1] ^ xt(ex[i-1]);
            lg[ex[i]] = i;
        end
        for (int a = 0; a < 256; a++) begin
            b = (a == 0) ? 8'h00 : ex[(255 - lg[a]) % 255];
            sbox[a] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
            inv_sbox[sbox[a]] = 8'(a);
        end
    endtask

    task automatic expand_and_load(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        for (int i = 0; i < 16; i++) key_store[i] = (i < 11) ? rk_tab[i] : '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        if (!in_ready) check({tag, "_ready_timeout"}, 128'(in_ready), 128'(1));
    endtask

    task automatic run_block(input logic [127:0] ct, input logic [127:0] exp, input int stall,
                             input bit garbage, input string tag);
        int lat;
        wait_ready(tag);
        out_ready = (stall == 0);
        in_valid  = 1'b1;
        in_data   = ct;
        tick();
        in_valid = 1'b0;
        in_data  = rand128();
        check({tag, "_init_state"}, dp_state, ct);
        check({tag, "_init_key"}, dp_key, key_store[10]);
        check({tag, "_busy"}, 128'(busy), 128'(1));
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            if (out_valid) begin
                lat = k;
                break;
            end
            if (k <= 11) check($sformatf("%s_key_addr_%0d", tag, k), 128'(key_addr), 128'(11 - k));
            if (k >= 2 && k <= 10)
                check($sformatf("%s_round_idx_%0d", tag, k), 128'(round_idx), 128'(11 - k));
            in_valid = garbage && (k == 6);
            if (garbage && k == 6) in_data = rand128();
            tick();
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, 128'(lat), 128'(12));
        check({tag, "_out_data"}, out_data, exp);
        check({tag, "_busy_done"}, 128'(busy), 128'(0));
        for (int s = 0; s < stall; s++) begin
            check($sformatf("%s_hold_valid_%0d", tag, s), 128'(out_valid), 128'(1));
            check($sformatf("%s_hold_data_%0d", tag, s), out_data, exp);
            check($sformatf("%s_hold_in_ready_%0d", tag, s), 128'(in_ready), 128'(0));
            tick();
        end
        out_ready = 1'b1;
        check({tag, "_valid_at_hs"}, 128'(out_valid), 128'(1));
        tick();
        check({tag, "_valid_after_hs"}, 128'(out_valid), 128'(0));
        check({tag, "_in_ready_after_hs"}, 128'(in_ready), 128'(1));
    endtask

    initial begin
        logic [127:0] ct;
        logic [127:0] o1, o2;
        int           extra, n_acc, n_out, a1, a2, t1, t2;
        bit           acc_now;

        build_tables();
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) key_store[i] = '0;
        tick();
        tick();

        // Power-up reset values
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_data", out_data, 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_round_idx", 128'(round_idx), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_key_addr", 128'(key_addr), 128'(0));
        check("rst_dp_state", dp_state, 128'(0));
        reset = 1'b1;

        // FIPS-197 C.1 vector
        expand_and_load(C1_KEY);
        run_block(C1_CT, C1_PT, 0, 1'b0, "c1");

        // Backpressure on a random key/ciphertext pair
        expand_and_load(rand128());
        ct = rand128();
        run_block(ct, ref_decrypt(ct), 5, 1'b0, "bp");

        // in_valid pulse with garbage during ROUND must be ignored
        expand_and_load(rand128());
        ct = rand128();
        run_block(ct, ref_decrypt(ct), 0, 1'b1, "ign");
        extra = 0;
        repeat (15) begin
            if (out_valid || !in_ready) extra++;
            tick();
        end
        check("ign_no_extra_activity", 128'(extra), 128'(0));

        // Back-to-back: C.1 then Appendix B, in_valid held high, store reloaded between
        expand_and_load(C1_KEY);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = C1_CT;
        n_acc = 0; n_out = 0; a1 = -100; a2 = -100; t1 = -100; t2 = -100;
        o1 = '0; o2 = '0;
        for (int t = 0; t < 60 && n_out < 2; t++) begin
            if (out_valid) begin
                if (n_out == 0) begin o1 = out_data; t1 = t; end
                else begin o2 = out_data; t2 = t; end
                n_out++;
            end
            acc_now = in_valid && in_ready;
            if (acc_now) begin
                if (n_acc == 0) a1 = t; else a2 = t;
                n_acc++;
            end
            if (n_acc == 1 && t == a1 + 12) expand_and_load(B_KEY);
            tick();
            if (acc_now && n_acc == 1) in_data = B_CT;
            if (acc_now && n_acc == 2) begin
                in_valid = 1'b0;
                in_data  = rand128();
            end
        end
        in_valid = 1'b0;
        check("b2b_accept_gap", 128'(a2 - a1), 128'(13));
        check("b2b_lat1", 128'(t1 - a1), 128'(12));
        check("b2b_lat2", 128'(t2 - a2), 128'(12));
        check("b2b_pt1", o1, C1_PT);
        check("b2b_pt2", o2, B_PT);
        tick();

        // Reset asserted at A+6 for two cycles aborts the block
        expand_and_load(C1_KEY);
        wait_ready("rst_mid");
        in_valid = 1'b1;
        in_data  = C1_CT;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        check("rst_mid_busy_before", 128'(busy), 128'(1));
        reset = 1'b0;
        #1;
        check("rst_mid_out_valid", 128'(out_valid), 128'(0));
        check("rst_mid_busy", 128'(busy), 128'(0));
        check("rst_mid_key_addr", 128'(key_addr), 128'(0));
        check("rst_mid_in_ready", 128'(in_ready), 128'(1));
        check("rst_mid_round_idx", 128'(round_idx), 128'(0));
        check("rst_mid_out_data", out_data, 128'(0));
        tick();
        check("rst_mid_out_valid_2", 128'(out_valid), 128'(0));
        tick();
        reset = 1'b1;
        check("rst_rel_in_ready", 128'(in_ready), 128'(1));
        check("rst_rel_out_valid", 128'(out_valid), 128'(0));
        run_block(C1_CT, C1_PT, 0, 1'b0, "post_rst");

        // Randomised blocks with random backpressure and stray in_valid pulses
        for (int b = 0; b < 4; b++) begin
            expand_and_load(rand128());
            ct = rand128();
            run_block(ct, ref_decrypt(ct), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      $sformatf("rnd%0d", b));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
